instruction_encoder_loader: RTL and testbench

//  Inverse of the immediate decode path: packs op/register/funct/immediate fields into 32-bit
//  RV32I instruction words and writes them sequentially into instruction memory.

---
 rtl/instruction_encoder_loader_if.sv | 34 +++
 rtl/instruction_encoder_loader.sv | 191 +++++++++++++++++++
 tb/tb_instruction_encoder_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_loader_if.sv
// ----------------------------------------------------------------------------
// instruction_encoder_loader_if
//   Groups the field-input handshake and the instruction-memory write bus of
//   instruction_encoder_loader.
//   Field side : valid_i / ready_o handshake plus op, rd, rs1, rs2, funct3,
//                funct7 and the sign-extended immediate.
//   Memory side: one-cycle write strobe with registered byte address and data.
//   Modports   : slave  = the encoder/loader block
//                master = whoever supplies fields and consumes the writes
// ----------------------------------------------------------------------------
interface instruction_encoder_loader_if;
    logic        valid_i;
    logic        ready_o;
    logic [6:0]  op_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] imm_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;

    modport slave (
        input  valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        output ready_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output valid_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        input  ready_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/instruction_encoder_loader.sv
// ----------------------------------------------------------------------------
// instruction_encoder_loader
//   Packs opcode/register/funct/immediate fields into 32-bit RV32I words
//   (I, S, U and R formats) and writes them to consecutive word addresses of
//   instruction memory starting at BASE_ADDR. Rejects unknown opcodes and
//   immediates that do not fit their format.
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   clear_i    : synchronous clear (index -> 0, in-flight word dropped)
//   bus        : field handshake + memory write bus (slave modport)
//   count_o    : words written since reset/clear
//   full_o     : count_o == DEPTH
//   err_o      : one-cycle pulse when a word is rejected
//   err_code_o : 01 bad opcode, 10 immediate out of range; held until the
//                next accept or clear
// ----------------------------------------------------------------------------
module instruction_encoder_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_i,
    instruction_encoder_loader_if.slave    bus,
    output logic [7:0]                     count_o,
    output logic                           full_o,
    output logic                           err_o,
    output logic [1:0]                     err_code_o
);
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_U = 7'b0110111;
    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_WRITE, S_FULL} state_t;

    state_t      state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [2:0]  f3_q, f3_d;
    logic [6:0]  f7_q, f7_d;
    logic [31:0] imm_q, imm_d;
    logic [7:0]  count_q, count_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [31:0] enc_word;
    logic        bad_op;
    logic        bad_imm;

    // Format packing and range check from the registered fields.
    always_comb begin
        enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
        bad_op   = 1'b0;
        bad_imm  = 1'b0;
        case (op_q)
            OP_I: begin
                enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                bad_imm  = (imm_q[31:11] != {21{imm_q[11]}});
            end
            OP_S: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                bad_imm  = (imm_q[31:11] != {21{imm_q[11]}});
            end
            OP_U: begin
                // imm carries the 20-bit upper value unshifted, sign-extended
                enc_word = {imm_q[19:0], rd_q, op_q};
                bad_imm  = (imm_q[31:19] != {13{imm_q[19]}});
            end
            OP_R: begin
                enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        f3_d       = f3_q;
        f7_d       = f7_q;
        imm_d      = imm_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (bus.valid_i) begin
                    op_d       = bus.op_i;
                    rd_d       = bus.rd_i;
                    rs1_d      = bus.rs1_i;
                    rs2_d      = bus.rs2_i;
                    f3_d       = bus.funct3_i;
                    f7_d       = bus.funct7_i;
                    imm_d      = bus.imm_i;
                    err_code_d = 2'b00;
                    state_d    = S_ENCODE;
                end
            end
            S_ENCODE: begin
                if (bad_op) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    state_d    = S_IDLE;
                end else if (bad_imm) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    state_d    = S_IDLE;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {22'd0, count_q, 2'b00};
                    data_d  = enc_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_q + 8'd1;
                state_d = (count_q + 8'd1 == DEPTH_C) ? S_FULL : S_IDLE;
            end
            default: ; // S_FULL waits for clear_i
        endcase

        // Clear overrides everything, including an accept in the same cycle.
        if (clear_i) begin
            state_d    = S_IDLE;
            count_d    = 8'd0;
            we_d       = 1'b0;
            err_d      = 1'b0;
            err_code_d = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= 7'd0;
            rd_q       <= 5'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            f3_q       <= 3'd0;
            f7_q       <= 7'd0;
            imm_q      <= 32'd0;
            count_q    <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            f3_q       <= f3_d;
            f7_q       <= f7_d;
            imm_q      <= imm_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign bus.ready_o    = (state_q == S_IDLE);
    // A clear arriving during the WRITE cycle kills that cycle's strobe too.
    assign bus.mem_we_o   = we_q & ~clear_i;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_data_o = data_q;
    assign count_o        = count_q;
    assign full_o         = (count_q == DEPTH_C);
    assign err_o          = err_q;
    assign err_code_o     = err_code_q;
endmodule

// File: tb/tb_instruction_encoder_loader.sv
module tb_instruction_encoder_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear_i = 1'b0;
    logic [7:0] count_o;
    logic       full_o;
    logic       err_o;
    logic [1:0] err_code_o;

    instruction_encoder_loader_if bus_if();

    instruction_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (clear_i),
        .bus        (bus_if),
        .count_o    (count_o),
        .full_o     (full_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_count = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          fmt;   // 1 I, 2 S, 3 U, 4 R
        int          imm;
        int          acc_cyc;
    } wr_t;

    typedef struct {
        logic [1:0] code;
        int         acc_cyc;
    } er_t;

    wr_t exp_wr[$];
    er_t exp_er[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: format from opcode, range from signed bounds, word by arithmetic.
    function automatic void model(input int op, input int rd, input int rs1, input int rs2,
                                  input int f3, input int f7, input int imm,
                                  output logic [1:0] code, output logic [31:0] word,
                                  output int fmt);
        logic [31:0] u;
        u    = imm;
        word = 32'd0;
        code = 2'b00;
        case (op)
            'h13: fmt = 1;
            'h23: fmt = 2;
            'h37: fmt = 3;
            'h33: fmt = 4;
            default: fmt = 0;
        endcase
        if (fmt == 0) code = 2'b01;
        else if ((fmt == 1 || fmt == 2) && (imm < -2048 || imm > 2047)) code = 2'b10;
        else if (fmt == 3 && (imm < -524288 || imm > 524287)) code = 2'b10;
        case (fmt)
            1: word = ((u & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (32'(rd) << 7) | 32'(op);
            2: word = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'(op);
            3: word = ((u & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'(op);
            4: word = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                      | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
            default: word = 32'd0;
        endcase
    endfunction

    // Standard RV32I immediate decode, used for the round-trip check.
    function automatic int decode_imm(input int fmt, input logic [31:0] d);
        int v;
        case (fmt)
            1: v = $signed(d) >>> 20;
            2: v = $signed({d[31:25], d[11:7]});
            default: v = $signed(d) >>> 12;
        endcase
        return v;
    endfunction

    task automatic scramble();
        bus_if.op_i     = 7'($urandom());
        bus_if.rd_i     = 5'($urandom());
        bus_if.rs1_i    = 5'($urandom());
        bus_if.rs2_i    = 5'($urandom());
        bus_if.funct3_i = 3'($urandom());
        bus_if.funct7_i = 7'($urandom());
        bus_if.imm_i    = $urandom();
    endtask

    // mode 0: normal; 1: clear in ENCODE; 2: clear in WRITE; 3: reset in WRITE.
    // lit != 0 replaces the model's word with a known-good constant.
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm, input int mode,
                        input logic [31:0] lit);
        int          waited;
        logic [1:0]  code;
        logic [31:0] word;
        int          fmt;
        wr_t         w;
        er_t         e;
        waited = 0;
        @(negedge clk);
        while (!bus_if.ready_o && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus_if.ready_o) begin
            errors++;
            $display("FAIL ready_timeout: ready_o=%0b required 1", bus_if.ready_o);
            return;
        end
        bus_if.op_i     = 7'(op);
        bus_if.rd_i     = 5'(rd);
        bus_if.rs1_i    = 5'(rs1);
        bus_if.rs2_i    = 5'(rs2);
        bus_if.funct3_i = 3'(f3);
        bus_if.funct7_i = 7'(f7);
        bus_if.imm_i    = imm;
        bus_if.valid_i  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.valid_i = 1'b0;
        scramble();
        if (mode == 0) begin
            model(op, rd, rs1, rs2, f3, f7, imm, code, word, fmt);
            if (code == 2'b00) begin
                w.addr    = BASE + 32'(model_count) * 4;
                w.data    = (lit != 32'd0) ? lit : word;
                w.fmt     = fmt;
                w.imm     = imm;
                w.acc_cyc = cyc;
                exp_wr.push_back(w);
                model_count++;
            end else begin
                e.code    = code;
                e.acc_cyc = cyc;
                exp_er.push_back(e);
            end
        end else if (mode == 1) begin
            clear_i = 1'b1;
            @(posedge clk); #1;
            clear_i = 1'b0;
            model_count = 0;
        end else if (mode == 2) begin
            @(posedge clk); #1;
            clear_i = 1'b1;
            @(posedge clk); #1;
            clear_i = 1'b0;
            model_count = 0;
        end else begin
            @(posedge clk); #1;
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            model_count = 0;
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        model_count = 0;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (bus_if.mem_we_o) begin
                $display("WR  addr=%h data=%h", bus_if.mem_addr_o, bus_if.mem_data_o);
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %h data %h, none required",
                             bus_if.mem_addr_o, bus_if.mem_data_o);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus_if.mem_addr_o, w.addr);
                    chk("wr_data", bus_if.mem_data_o, w.data);
                    chk("wr_latency", 32'(cyc - w.acc_cyc), 32'd1);
                    if (w.fmt >= 1 && w.fmt <= 3)
                        chk("roundtrip_imm", 32'(decode_imm(w.fmt, bus_if.mem_data_o)), 32'(w.imm));
                end
            end
            if (err_o) begin
                $display("ERR code=%b", err_code_o);
                if (exp_er.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_err: code %b, none required", err_code_o);
                end else begin
                    er_t e;
                    e = exp_er.pop_front();
                    chk("err_code", 32'(err_code_o), 32'(e.code));
                    chk("err_latency", 32'(cyc - e.acc_cyc), 32'd1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, imm, sel;
        bus_if.valid_i = 1'b0;
        scramble();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus_if.ready_o), 32'd1);
        chk("rst_we", 32'(bus_if.mem_we_o), 32'd0);
        chk("rst_addr", bus_if.mem_addr_o, 32'd0);
        chk("rst_data", bus_if.mem_data_o, 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
        reset = 1'b1;

        // Directed words with known encodings
        send('h13, 5, 0, 0, 0, 0, -1, 0, 32'hFFF0_0293);
        settle();
        chk("count_after_addi", 32'(count_o), 32'd1);
        send('h23, 0, 2, 6, 2, 0, 8, 0, 32'h0061_2423);
        send('h37, 1, 0, 0, 0, 0, 'h12345, 0, 32'h1234_50B7);
        settle();
        chk("count_after_3", 32'(count_o), 32'd3);

        // Rejects
        send('h13, 1, 1, 0, 0, 0, 'h800, 0, 32'd0);
        settle();
        chk("held_code_imm", 32'(err_code_o), 32'd2);
        send('h37, 1, 0, 0, 0, 0, 'h80000, 0, 32'd0);
        send('h63, 1, 1, 1, 0, 0, 4, 0, 32'd0);
        settle();
        chk("held_code_op", 32'(err_code_o), 32'd1);
        send('h63, 1, 1, 1, 0, 0, 'h7FFF_0000, 0, 32'd0);
        settle();
        chk("count_after_rejects", 32'(count_o), 32'd3);

        // Boundary immediate fills the memory
        send('h13, 3, 4, 0, 1, 0, -2048, 0, 32'd0);
        settle();
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_flag", 32'(full_o), 32'd1);
        chk("full_ready", 32'(bus_if.ready_o), 32'd0);
        chk("full_code_cleared", 32'(err_code_o), 32'd0);
        bus_if.op_i = 7'h13; bus_if.imm_i = 32'd1; bus_if.valid_i = 1'b1;
        repeat (5) @(negedge clk);
        bus_if.valid_i = 1'b0;
        chk("full_ignore_count", 32'(count_o), 32'd4);
        chk("full_ignore_ready", 32'(bus_if.ready_o), 32'd0);
        do_clear();
        chk("clear_count", 32'(count_o), 32'd0);
        chk("clear_ready", 32'(bus_if.ready_o), 32'd1);
        chk("clear_full", 32'(full_o), 32'd0);

        // Aborts
        send('h13, 2, 2, 0, 0, 0, 7, 1, 32'd0);
        settle();
        chk("abort_enc_count", 32'(count_o), 32'd0);
        send('h33, 7, 8, 9, 0, 'h20, 0, 0, 32'd0);
        send('h13, 2, 2, 0, 0, 0, 9, 3, 32'd0);
        settle();
        chk("abort_rst_count", 32'(count_o), 32'd0);
        send('h37, 9, 0, 0, 0, 0, -524288, 0, 32'd0);
        send('h23, 0, 3, 4, 2, 0, 2047, 2, 32'd0);
        settle();
        chk("abort_wr_count", 32'(count_o), 32'd0);

        // Random legal I/S/U round-trips
        for (int i = 0; i < 200; i++) begin
            if (model_count == DEPTH) begin
                settle();
                chk("rand_full", 32'(full_o), 32'd1);
                do_clear();
            end
            sel = int'($urandom_range(0, 2));
            op  = (sel == 0) ? 'h13 : (sel == 1) ? 'h23 : 'h37;
            if (sel == 2) imm = int'($urandom_range(0, 1048575)) - 524288;
            else          imm = int'($urandom_range(0, 4095)) - 2048;
            send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)), imm, 0, 32'd0);
        end

        // Random mix including R-type, bad opcodes and out-of-range immediates
        for (int i = 0; i < 40; i++) begin
            if (model_count == DEPTH) begin
                settle();
                do_clear();
            end
            sel = int'($urandom_range(0, 4));
            op  = (sel == 0) ? 'h13 : (sel == 1) ? 'h23 : (sel == 2) ? 'h37 :
                  (sel == 3) ? 'h33 : int'($urandom_range(0, 127));
            imm = ($urandom_range(0, 1) == 1) ? int'($urandom()) : int'($urandom_range(0, 4000)) - 2000;
            send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 127)), imm, 0, 32'd0);
        end

        settle();
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("err_queue_empty", 32'(exp_er.size()), 32'd0);
        chk("final_count", 32'(count_o), 32'(model_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
